uartbone_bridge: RTL

UARTBONE_BRIDGE -- requirements
Module: uartbone_bridge

---
 rtl/uartbone_pkg.sv | 19 +
 rtl/uartbone_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uartbone_pkg.sv
// uartbone_pkg
//   Command codes and FSM state encoding shared by the UART-to-Wishbone
//   bridge and anything that needs to build or decode its byte protocol.
package uartbone_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        ADDR,
        WDATA,
        WB_WR,
        WB_RD,
        TXDATA
    } state_t;

endpackage

// File: rtl/uartbone_bridge.sv
// uartbone_bridge
//   Turns a byte stream from a UART receiver into Wishbone word accesses.
//   Frame: cmd, word count N, 4 address bytes (MSB first), then for writes
//   N*4 data bytes (MSB first per word). Read data goes back as 4 bytes
//   per word, MSB first. A stalled frame is dropped after TIMEOUT_CYCLES
//   idle cycles; bus cycles themselves never time out.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_ready  byte stream in from the UART receiver
//   tx_data/tx_valid/tx_ready  byte stream out to the UART transmitter
//   wb_*                       Wishbone master (word addressed, 32-bit data)
module uartbone_bridge
    import uartbone_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int ADDR_WIDTH     = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [31:0]           wb_dat_w,
    input  logic [31:0]           wb_dat_r,
    output logic [3:0]            wb_sel,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    input  logic                  wb_ack
);

    localparam int             TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    logic          is_write;
    logic [7:0]    word_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   addr_shift;
    logic [23:0]   wr_shift;
    logic [23:0]   tx_shift;
    logic [TW-1:0] idle_cnt;

    logic          count_phase;
    logic          rx_fire;
    logic          tx_fire;
    logic          timeout;
    logic          last_byte;

    // Mid-frame receive states are the only ones watched by the idle timer.
    assign count_phase = (state == LEN) || (state == ADDR) || (state == WDATA);

    // Gated with rst_n so the receiver sees "not ready" while reset is held,
    // even though the state register already sits in IDLE.
    assign rx_ready  = rst_n && ((state == IDLE) || count_phase);
    assign rx_fire   = rx_valid && rx_ready;
    assign tx_fire   = tx_valid && tx_ready;
    assign timeout   = count_phase && !rx_fire && (idle_cnt == TIMEOUT_LAST);
    assign last_byte = (byte_cnt == 2'd3);

    // Bus strobes come straight from the state so a reset drops them at once.
    assign wb_cyc = (state == WB_WR) || (state == WB_RD);
    assign wb_stb = wb_cyc;
    assign wb_we  = (state == WB_WR);
    assign wb_sel = wb_cyc ? 4'hF : 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rx_fire && ((rx_data == CMD_WRITE) || (rx_data == CMD_READ))) begin
                    next_state = LEN;
                end
            end
            LEN: begin
                if (rx_fire) begin
                    next_state = ADDR;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            ADDR: begin
                if (rx_fire && last_byte) begin
                    if (word_cnt == 8'd0) begin
                        next_state = IDLE;
                    end else if (is_write) begin
                        next_state = WDATA;
                    end else begin
                        next_state = WB_RD;
                    end
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            WDATA: begin
                if (rx_fire && last_byte) begin
                    next_state = WB_WR;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            WB_WR: begin
                if (wb_ack) begin
                    next_state = (word_cnt == 8'd1) ? IDLE : WDATA;
                end
            end
            WB_RD: begin
                if (wb_ack) begin
                    next_state = TXDATA;
                end
            end
            TXDATA: begin
                // word_cnt was already decremented on the ack of this word.
                if (tx_fire && last_byte) begin
                    next_state = (word_cnt == 8'd0) ? IDLE : WB_RD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: byte assembly, address/count bookkeeping, TX serialisation
    // and the inter-byte idle timer. byte_cnt is 2 bits and wraps to 0 after
    // each 4-byte group, so it is ready for the next group without a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write   <= 1'b0;
            word_cnt   <= 8'd0;
            byte_cnt   <= 2'd0;
            addr_shift <= 24'd0;
            wr_shift   <= 24'd0;
            tx_shift   <= 24'd0;
            idle_cnt   <= '0;
            wb_adr     <= '0;
            wb_dat_w   <= 32'd0;
            tx_data    <= 8'd0;
            tx_valid   <= 1'b0;
        end else begin
            if (!count_phase || rx_fire || timeout) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TW'(1);
            end

            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        is_write <= (rx_data == CMD_WRITE);
                    end
                end
                LEN: begin
                    if (rx_fire) begin
                        word_cnt <= rx_data;
                        byte_cnt <= 2'd0;
                    end
                end
                ADDR: begin
                    if (rx_fire) begin
                        addr_shift <= {addr_shift[15:0], rx_data};
                        byte_cnt   <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            // Upper address bits beyond ADDR_WIDTH are dropped.
                            wb_adr <= ADDR_WIDTH'({addr_shift, rx_data});
                        end
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        wr_shift <= {wr_shift[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (last_byte) begin
                            wb_dat_w <= {wr_shift, rx_data};
                        end
                    end
                end
                WB_WR: begin
                    if (wb_ack) begin
                        wb_adr   <= wb_adr + ADDR_WIDTH'(1);
                        word_cnt <= word_cnt - 8'd1;
                    end
                end
                WB_RD: begin
                    if (wb_ack) begin
                        wb_adr   <= wb_adr + ADDR_WIDTH'(1);
                        word_cnt <= word_cnt - 8'd1;
                        tx_data  <= wb_dat_r[31:24];
                        tx_shift <= wb_dat_r[23:0];
                        tx_valid <= 1'b1;
                        byte_cnt <= 2'd0;
                    end
                end
                TXDATA: begin
                    if (tx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        tx_data  <= tx_shift[23:16];
                        tx_shift <= {tx_shift[15:0], 8'h00};
                        if (last_byte) begin
                            tx_valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
